// File: rtl/countdown_timer.sv
// countdown_timer: minutes:seconds countdown with prescaler, pause/resume and
// expiry flag. Shares the stopwatch time format (8-bit min, 6-bit sec, 2-bit status).
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | count loaded or cleared, waiting for start
//  RUNNING | prescaler advancing, count decrements once per second
//  PAUSED  | count and prescaler frozen, start resumes
//  EXPIRED | count reached 00:00, only load or rst leaves
module countdown_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] status,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;

    logic [5:0]    preset_sec;
    logic          count_zero;

    assign preset_sec = (load_sec > 6'd59) ? 6'd59 : load_sec;
    assign count_zero = (min_q == 8'd0) && (sec_q == 6'd0);

    // State and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            min_q   <= 8'd0;
            sec_q   <= 6'd0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // Next-state, count and prescaler logic; load > stop > start.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    min_d   = load_min;
                    sec_d   = preset_sec;
                    presc_d = '0;
                end else if (stop) begin
                    state_d = IDLE;
                end else if (start && !count_zero) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                // stop beats a coincident decrement, so the prescaler stays at
                // its terminal value and the tick fires right after resume.
                if (stop) begin
                    state_d = PAUSED;
                end else if (presc_q == PRESC_TC) begin
                    presc_d = '0;
                    if (sec_q != 6'd0) begin
                        sec_d = sec_q - 6'd1;
                        if ((min_q == 8'd0) && (sec_q == 6'd1)) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        sec_d = 6'd59;
                        min_d = min_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            PAUSED: begin
                if (load) begin
                    min_d   = load_min;
                    sec_d   = preset_sec;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (stop) begin
                    state_d = PAUSED;
                end else if (start) begin
                    state_d = RUNNING;
                end
            end
            EXPIRED: begin
                if (load) begin
                    min_d   = load_min;
                    sec_d   = preset_sec;
                    presc_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign status  = state_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC = 4.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       stop;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic       done;

    int total = 0;
    int bad   = 0;

    countdown_timer #(.TICKS_PER_SEC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .stop     (stop),
        .minutes  (minutes),
        .seconds  (seconds),
        .status   (status),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int m, input int s, input int st, input int d);
        chk({tag, ".min"},    32'(minutes), 32'(m));
        chk({tag, ".sec"},    32'(seconds), 32'(s));
        chk({tag, ".status"}, 32'(status),  32'(st));
        chk({tag, ".done"},   32'(done),    32'(d));
    endtask

    task automatic do_load(input int m, input int s);
        load_min = 8'(m);
        load_sec = 6'(s);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_min = 8'd0; load_sec = 6'd0;
        start = 1'b0; stop = 1'b0;

        // Reset and basic countdown 00:03
        cyc(); cyc();
        rst = 1'b0;
        chk_all("reset", 0, 0, 0, 0);
        do_load(0, 3);
        chk_all("load3", 0, 3, 0, 0);
        do_start();
        chk_all("run_entry", 0, 3, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("cd.sec", 32'(seconds), 32'(3 - i / 4));
            chk("cd.done", 32'(done), (i == 12) ? 32'd1 : 32'd0);
            chk("cd.status", 32'(status), (i == 12) ? 32'd3 : 32'd1);
        end
        cyc();
        chk_all("expired_hold", 0, 0, 3, 0);
        do_start();
        chk_all("start_in_expired", 0, 0, 3, 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_all("stop_in_expired", 0, 0, 3, 0);

        // Minute borrow 02:00
        do_load(2, 0);
        chk_all("load2m", 2, 0, 0, 0);
        do_start();
        repeat (3) cyc();
        chk_all("borrow_pre", 2, 0, 1, 0);
        cyc();
        chk_all("borrow", 1, 59, 1, 0);
        repeat (475) cyc();
        chk_all("borrow_last", 0, 1, 1, 0);
        cyc();
        chk_all("borrow_expire", 0, 0, 3, 1);

        // Pause / resume 00:05
        do_load(0, 5);
        do_start();
        repeat (6) cyc();
        chk_all("pr_before_stop", 0, 4, 1, 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_all("pr_paused", 0, 4, 2, 0);
        repeat (20) cyc();
        chk_all("pr_held", 0, 4, 2, 0);
        do_start();
        chk_all("pr_resume", 0, 4, 1, 0);
        cyc();
        chk_all("pr_resume1", 0, 4, 1, 0);
        cyc();
        chk_all("pr_resume2", 0, 3, 1, 0);

        // Ignored / simultaneous controls
        do_load(1, 0);
        chk_all("load_while_run", 0, 3, 1, 0);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk_all("startstop_run", 0, 3, 2, 0);
        start = 1'b1; do_load(1, 2); start = 1'b0;
        chk_all("loadstart_paused", 1, 2, 0, 0);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk_all("startstop_idle", 1, 2, 0, 0);
        do_load(0, 63);
        chk_all("sat_sec", 0, 59, 0, 0);
        do_load(255, 59);
        chk_all("max_preset", 255, 59, 0, 0);
        do_load(0, 0);
        do_start();
        chk_all("start_at_zero", 0, 0, 0, 0);

        // stop coincident with final decrement
        do_load(0, 1);
        do_start();
        repeat (3) cyc();
        chk_all("final_pre", 0, 1, 1, 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_all("final_stop", 0, 1, 2, 0);
        do_start();
        chk_all("final_resume", 0, 1, 1, 0);
        cyc();
        chk_all("final_expire", 0, 0, 3, 1);

        // Reset mid-run at 03:27
        do_load(3, 27);
        do_start();
        repeat (2) cyc();
        chk_all("pre_rst", 3, 27, 1, 0);
        rst = 1'b1; start = 1'b1; stop = 1'b1; cyc();
        rst = 1'b0; stop = 1'b0;
        chk_all("mid_rst", 0, 0, 0, 0);
        cyc();
        start = 1'b0;
        chk_all("start_after_rst", 0, 0, 0, 0);
        do_load(0, 2);
        do_start();
        chk_all("start_after_load", 0, 2, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
